// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int MULDIV_XLEN = 32;
   localparam int CNT_W       = $clog2(MULDIV_XLEN);

   localparam logic [2:0] FN_MUL    = 3'd0;
   localparam logic [2:0] FN_MULH   = 3'd1;
   localparam logic [2:0] FN_MULHSU = 3'd2;
   localparam logic [2:0] FN_MULHU  = 3'd3;
   localparam logic [2:0] FN_DIV    = 3'd4;
   localparam logic [2:0] FN_DIVU   = 3'd5;
   localparam logic [2:0] FN_REM    = 3'd6;
   localparam logic [2:0] FN_REMU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage handshake between the ID/EX pipeline register (master) and the mul/div unit (slave).
interface ex_muldiv_if #(parameter int XLEN = 32);

   logic            StartE;
   logic [2:0]      FunctE;
   logic [XLEN-1:0] SrcAE;
   logic [XLEN-1:0] SrcBE;
   logic [4:0]      RdE;
   logic            FlushE;
   logic            StallE;
   logic            DoneE;
   logic [XLEN-1:0] ResultE;
   logic [4:0]      RdME;

   modport master (
      output StartE, FunctE, SrcAE, SrcBE, RdE, FlushE,
      input  StallE, DoneE, ResultE, RdME
   );

   modport slave (
      input  StartE, FunctE, SrcAE, SrcBE, RdE, FlushE,
      output StallE, DoneE, ResultE, RdME
   );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration on the {hi, lo} working register: a restoring-divide
// step (lo = dividend/quotient, hi = remainder) or a shift-add multiply step (lo = multiplier).
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              is_div,
   input  logic [2*XLEN-1:0] work_in,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN-1:0] work_out
);

   logic [XLEN:0] partial;
   logic [XLEN:0] diff;
   logic [XLEN:0] sum;

   // The partial remainder keeps its shifted-out MSB so divisors >= 2^(XLEN-1) still work.
   always_comb begin
      partial = work_in[2*XLEN-1:XLEN-1];
      diff    = partial - {1'b0, operand};
      sum     = {1'b0, work_in[2*XLEN-1:XLEN]} + (work_in[0] ? {1'b0, operand} : '0);
      if (is_div) begin
         if (!diff[XLEN]) begin
            work_out = {diff[XLEN-1:0], work_in[XLEN-2:0], 1'b1};
         end else begin
            work_out = {partial[XLEN-1:0], work_in[XLEN-2:0], 1'b0};
         end
      end else begin
         work_out = {sum, work_in[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in EX; stalls the pipeline while running.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies (divides stay iterative).
module ex_muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic        clk,
   input logic        reset,
   ex_muldiv_if.slave bus
);

   state_t            state;
   state_t            next_state;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] work;
   logic [2*XLEN-1:0] step_out;
   logic [XLEN-1:0]   op_b;
   logic [XLEN-1:0]   special_val_q;
   logic [2:0]        funct_q;
   logic [4:0]        rd_q;
   logic              neg_q;
   logic              neg_r;
   logic              special_q;

   logic              start_go;
   logic              start_special;
   logic [XLEN-1:0]   special_val;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic              neg_a;
   logic              neg_b;
   logic              is_div;
   logic [2*XLEN-1:0] prod_signed;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   core_result;
   logic [XLEN-1:0]   result_final;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
`endif

   // Operand decode in IDLE: magnitudes, sign flags and the results that need no iteration.
   always_comb begin
      is_div        = bus.FunctE[2];
      neg_a         = bus.SrcAE[XLEN-1] & ((bus.FunctE == FN_MULH) || (bus.FunctE == FN_MULHSU) ||
                                           (bus.FunctE == FN_DIV)  || (bus.FunctE == FN_REM));
      neg_b         = bus.SrcBE[XLEN-1] & ((bus.FunctE == FN_MULH) ||
                                           (bus.FunctE == FN_DIV)  || (bus.FunctE == FN_REM));
      mag_a         = neg_a ? -bus.SrcAE : bus.SrcAE;
      mag_b         = neg_b ? -bus.SrcBE : bus.SrcBE;
      start_go      = (state == IDLE) && bus.StartE && !bus.FlushE;
      start_special = 1'b0;
      special_val   = '0;
`ifdef MULDIV_FAST_MUL_EN
      fast_prod     = {{XLEN{neg_a}}, bus.SrcAE} * {{XLEN{neg_b}}, bus.SrcBE};
`endif
      if (is_div && (bus.SrcBE == '0)) begin
         start_special = 1'b1;
         special_val   = bus.FunctE[1] ? bus.SrcAE : '1;
      end else if (is_div && !bus.FunctE[0] && (bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (bus.SrcBE == '1)) begin
         start_special = 1'b1;
         special_val   = bus.FunctE[1] ? '0 : bus.SrcAE;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (!is_div) begin
         start_special = 1'b1;
         special_val   = (bus.FunctE == FN_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
      end
`endif
   end

   muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div   (funct_q[2]),
      .work_in  (work),
      .operand  (op_b),
      .work_out (step_out)
   );

   // Sign correction and half/quotient/remainder selection applied in DONE.
   always_comb begin
      prod_signed = neg_q ? -work : work;
      quot        = neg_q ? -work[XLEN-1:0] : work[XLEN-1:0];
      rem         = neg_r ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
      case (funct_q)
         FN_MUL:                        core_result = prod_signed[XLEN-1:0];
         FN_MULH, FN_MULHSU, FN_MULHU:  core_result = prod_signed[2*XLEN-1:XLEN];
         FN_DIV, FN_DIVU:               core_result = quot;
         default:                       core_result = rem;
      endcase
      result_final = special_q ? special_val_q : core_result;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // StallE stays low in DONE so the instruction leaves EX as its result is captured.
   always_comb begin
      next_state = state;
      bus.StallE = 1'b0;
      bus.DoneE  = 1'b0;
      case (state)
         IDLE: begin
            if (start_go) begin
               bus.StallE = 1'b1;
               next_state = start_special ? DONE : RUN;
            end
         end
         RUN: begin
            bus.StallE = 1'b1;
            if (bus.FlushE) begin
               next_state = IDLE;
            end else if (cnt == CNT_W'(XLEN-1)) begin
               next_state = DONE;
            end
         end
         DONE: begin
            bus.DoneE  = !bus.FlushE;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath: latch operands on start, iterate in RUN, publish the result leaving DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt           <= '0;
         work          <= '0;
         op_b          <= '0;
         funct_q       <= '0;
         rd_q          <= '0;
         neg_q         <= 1'b0;
         neg_r         <= 1'b0;
         special_q     <= 1'b0;
         special_val_q <= '0;
         bus.ResultE   <= '0;
         bus.RdME      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_go) begin
                  cnt           <= '0;
                  work          <= {{XLEN{1'b0}}, mag_a};
                  op_b          <= mag_b;
                  funct_q       <= bus.FunctE;
                  rd_q          <= bus.RdE;
                  neg_q         <= neg_a ^ neg_b;
                  neg_r         <= neg_a;
                  special_q     <= start_special;
                  special_val_q <= special_val;
               end
            end
            RUN: begin
               work <= step_out;
               cnt  <= cnt + 1'b1;
            end
            DONE: begin
               if (!bus.FlushE) begin
                  bus.ResultE <= result_final;
                  bus.RdME    <= rd_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus randomized ops
// against an arithmetic reference model; honours MULDIV_FAST_MUL_EN.
module tb_ex_muldiv;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   ex_muldiv_if #(.XLEN(32)) bus_if ();

   ex_muldiv #(.XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Reference: RV32M semantics computed with plain 64-bit arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      p;
      logic [63:0] pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f[2] && b == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!f[2]) return 1;
`endif
      return 33;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         5:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Presents one instruction in EX as a pipeline would: held while stalled and through DONE.
   // Returns with the clock just past the edge leaving DONE (lat = -1 on timeout).
   task automatic apply_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, output int lat, output int stalls,
                           output int dones);
      lat    = -1;
      stalls = 0;
      dones  = 0;
      bus_if.StartE = 1'b1;
      bus_if.FunctE = f;
      bus_if.SrcAE  = a;
      bus_if.SrcBE  = b;
      bus_if.RdE    = rd;
      bus_if.FlushE = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus_if.StallE) stalls++;
         if (bus_if.DoneE) begin
            dones++;
            lat = k;
         end
         @(posedge clk);
         #1;
         if (lat >= 0) break;
      end
      bus_if.StartE = 1'b0;
   endtask

   task automatic idle_cycles(input int n, output int dones, output int stalls);
      dones  = 0;
      stalls = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (bus_if.DoneE) dones++;
         if (bus_if.StallE) stalls++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_if.StartE = 1'b0;
      bus_if.FunctE = 3'd0;
      bus_if.SrcAE  = 32'h0;
      bus_if.SrcBE  = 32'h0;
      bus_if.RdE    = 5'd0;
      bus_if.FlushE = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_if.StallE !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b want=0", bus_if.StallE); end
      checks++;
      if (bus_if.DoneE !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", bus_if.DoneE); end
      checks++;
      if (bus_if.ResultE !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got=%h want=0", bus_if.ResultE); end
      checks++;
      if (bus_if.RdME !== 5'd0) begin errors++; $display("[TB] FAIL reset_rd got=%0d want=0", bus_if.RdME); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [2:0]  tf [10] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0, 3'd1, 3'd3, 3'd2};
      logic [31:0] ta [10] = '{32'd20, 32'd20, 32'd5, 32'd7, 32'h8000_0000, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] tb [10] = '{-32'd3, -32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] te [10] = '{32'hFFFF_FFFA, 32'd2, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0,
                               32'd1, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      int lat, stalls, dones, el;
      for (int i = 0; i < 10; i++) begin
         el = ref_latency(tf[i], ta[i], tb[i]);
         apply_op(tf[i], ta[i], tb[i], 5'(i + 1), lat, stalls, dones);
         checks++;
         if (bus_if.ResultE !== te[i]) begin errors++; $display("[TB] FAIL dir_result[%0d] got=%h want=%h", i, bus_if.ResultE, te[i]); end
         checks++;
         if (bus_if.RdME !== 5'(i + 1)) begin errors++; $display("[TB] FAIL dir_rd[%0d] got=%0d want=%0d", i, bus_if.RdME, i + 1); end
         checks++;
         if (lat != el) begin errors++; $display("[TB] FAIL dir_latency[%0d] got=%0d want=%0d", i, lat, el); end
         checks++;
         if (stalls != el) begin errors++; $display("[TB] FAIL dir_stalls[%0d] got=%0d want=%0d", i, stalls, el); end
         checks++;
         if (dones != 1) begin errors++; $display("[TB] FAIL dir_dones[%0d] got=%0d want=1", i, dones); end
      end
   endtask

   task automatic test_back_to_back();
      int lat, stalls, dones, idle_dones, idle_stalls;
      apply_op(3'd4, 32'd20, -32'd3, 5'd5, lat, stalls, dones);
      checks++;
      if (bus_if.RdME !== 5'd5) begin errors++; $display("[TB] FAIL b2b_rd1 got=%0d want=5", bus_if.RdME); end
      checks++;
      if (dones != 1) begin errors++; $display("[TB] FAIL b2b_dones1 got=%0d want=1", dones); end
      apply_op(3'd5, 32'd9, 32'd2, 5'd6, lat, stalls, dones);
      checks++;
      if (bus_if.RdME !== 5'd6) begin errors++; $display("[TB] FAIL b2b_rd2 got=%0d want=6", bus_if.RdME); end
      checks++;
      if (bus_if.ResultE !== 32'd4) begin errors++; $display("[TB] FAIL b2b_result2 got=%h want=4", bus_if.ResultE); end
      checks++;
      if (dones != 1 || lat != 33) begin errors++; $display("[TB] FAIL b2b_op2 dones=%0d lat=%0d want 1/33", dones, lat); end
      idle_cycles(6, idle_dones, idle_stalls);
      checks++;
      if (idle_dones != 0) begin errors++; $display("[TB] FAIL b2b_extra_done got=%0d want=0", idle_dones); end
   endtask

   task automatic test_random();
      logic [2:0]  f;
      logic [31:0] a, b, exp;
      logic [4:0]  rd;
      int lat, stalls, dones, el;
      for (int i = 0; i < 30; i++) begin
         f   = 3'($urandom_range(0, 7));
         a   = pick_operand();
         b   = pick_operand();
         rd  = 5'($urandom_range(0, 31));
         exp = ref_result(f, a, b);
         el  = ref_latency(f, a, b);
         apply_op(f, a, b, rd, lat, stalls, dones);
         checks++;
         if (bus_if.ResultE !== exp) begin errors++; $display("[TB] FAIL rand_result f=%0d a=%h b=%h got=%h want=%h", f, a, b, bus_if.ResultE, exp); end
         checks++;
         if (bus_if.RdME !== rd) begin errors++; $display("[TB] FAIL rand_rd got=%0d want=%0d", bus_if.RdME, rd); end
         checks++;
         if (lat != el || stalls != el || dones != 1) begin
            errors++;
            $display("[TB] FAIL rand_timing f=%0d lat=%0d stalls=%0d dones=%0d want lat=stalls=%0d dones=1", f, lat, stalls, dones, el);
         end
      end
   endtask

   task automatic test_flush();
      int lat, stalls, dones, idle_dones, idle_stalls;
      apply_op(3'd5, 32'd9, 32'd2, 5'd3, lat, stalls, dones);
      checks++;
      if (bus_if.ResultE !== 32'd4) begin errors++; $display("[TB] FAIL flush_base got=%h want=4", bus_if.ResultE); end
      // Flush in RUN at t+10.
      bus_if.StartE = 1'b1;
      bus_if.FunctE = 3'd5;
      bus_if.SrcAE  = 32'd100;
      bus_if.SrcBE  = 32'd7;
      bus_if.RdE    = 5'd9;
      repeat (10) begin @(posedge clk); #1; end
      bus_if.FlushE = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_if.StallE !== 1'b1 || bus_if.DoneE !== 1'b0) begin errors++; $display("[TB] FAIL flush_t10 stall=%b done=%b want 1/0", bus_if.StallE, bus_if.DoneE); end
      @(posedge clk);
      #1;
      bus_if.StartE = 1'b0;
      bus_if.FlushE = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_if.StallE !== 1'b0 || bus_if.DoneE !== 1'b0) begin errors++; $display("[TB] FAIL flush_t11 stall=%b done=%b want 0/0", bus_if.StallE, bus_if.DoneE); end
      checks++;
      if (bus_if.ResultE !== 32'd4 || bus_if.RdME !== 5'd3) begin errors++; $display("[TB] FAIL flush_hold result=%h rd=%0d want 4/3", bus_if.ResultE, bus_if.RdME); end
      @(posedge clk);
      #1;
      idle_cycles(40, idle_dones, idle_stalls);
      checks++;
      if (idle_dones != 0 || idle_stalls != 0) begin errors++; $display("[TB] FAIL flush_after dones=%0d stalls=%0d want 0/0", idle_dones, idle_stalls); end
      // Flush in DONE at t+33.
      bus_if.StartE = 1'b1;
      repeat (33) begin @(posedge clk); #1; end
      bus_if.FlushE = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_if.DoneE !== 1'b0 || bus_if.StallE !== 1'b0) begin errors++; $display("[TB] FAIL flush_done done=%b stall=%b want 0/0", bus_if.DoneE, bus_if.StallE); end
      @(posedge clk);
      #1;
      bus_if.StartE = 1'b0;
      bus_if.FlushE = 1'b0;
      checks++;
      if (bus_if.ResultE !== 32'd4 || bus_if.RdME !== 5'd3) begin errors++; $display("[TB] FAIL flush_done_hold result=%h rd=%0d want 4/3", bus_if.ResultE, bus_if.RdME); end
   endtask

   task automatic test_flush_start_idle();
      int idle_dones, idle_stalls;
      bus_if.StartE = 1'b1;
      bus_if.FlushE = 1'b1;
      bus_if.FunctE = 3'd5;
      bus_if.SrcAE  = 32'd100;
      bus_if.SrcBE  = 32'd7;
      bus_if.RdE    = 5'd11;
      @(negedge clk);
      checks++;
      if (bus_if.StallE !== 1'b0) begin errors++; $display("[TB] FAIL flushstart_stall got=%b want=0", bus_if.StallE); end
      @(posedge clk);
      #1;
      bus_if.StartE = 1'b0;
      bus_if.FlushE = 1'b0;
      idle_cycles(40, idle_dones, idle_stalls);
      checks++;
      if (idle_dones != 0 || idle_stalls != 0) begin errors++; $display("[TB] FAIL flushstart_after dones=%0d stalls=%0d want 0/0", idle_dones, idle_stalls); end
   endtask

   task automatic test_reset_mid_op();
      int idle_dones, idle_stalls;
      bus_if.StartE = 1'b1;
      bus_if.FunctE = 3'd5;
      bus_if.SrcAE  = 32'd100;
      bus_if.SrcBE  = 32'd7;
      bus_if.RdE    = 5'd9;
      repeat (10) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus_if.StartE = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_if.StallE !== 1'b0 || bus_if.DoneE !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_t11 stall=%b done=%b want 0/0", bus_if.StallE, bus_if.DoneE); end
      checks++;
      if (bus_if.ResultE !== 32'h0 || bus_if.RdME !== 5'd0) begin errors++; $display("[TB] FAIL rstmid_regs result=%h rd=%0d want 0/0", bus_if.ResultE, bus_if.RdME); end
      @(posedge clk);
      #1;
      idle_cycles(40, idle_dones, idle_stalls);
      checks++;
      if (idle_dones != 0 || idle_stalls != 0) begin errors++; $display("[TB] FAIL rstmid_after dones=%0d stalls=%0d want 0/0", idle_dones, idle_stalls); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_flush();
      test_flush_start_idle();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
